// File: rtl/crc8_msg_framer_if.sv
// Stream-in / message-out bundle for the CRC-8 message framer.
interface crc8_msg_framer_if #(
  parameter int DATA_BYTES = 8,
  parameter int CNT_W      = 16
);
  logic [7:0]              s_data;
  logic                    s_valid;
  logic                    s_last;
  logic                    s_ready;
  logic                    chk_mode;
  logic [8*DATA_BYTES+7:0] M;
  logic                    m_valid;
  logic                    frm_err;
  logic [CNT_W-1:0]        frame_cnt;
  logic [CNT_W-1:0]        err_cnt;

  // Byte source / message sink side
  modport master (
    output s_data, s_valid, s_last, chk_mode,
    input  s_ready, M, m_valid, frm_err, frame_cnt, err_cnt
  );

  // Framer side
  modport slave (
    input  s_data, s_valid, s_last, chk_mode,
    output s_ready, M, m_valid, frm_err, frame_cnt, err_cnt
  );
endinterface

// File: rtl/crc8_msg_framer.sv
// Collects a byte stream into one {data, crc_field} message word for the
// CRC-8 core. Malformed (short/long) frames are dropped and counted.
module crc8_msg_framer #(
  parameter int DATA_BYTES = 8,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,   // active-low, asynchronous
  crc8_msg_framer_if.slave   bus
);
  localparam int MW    = 8*DATA_BYTES + 8;
  localparam int IDX_W = $clog2(DATA_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES-1);

  typedef enum logic [2:0] {IDLE, DATA, CRCB, DROP, ERR} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    mode_q;
  logic [8*DATA_BYTES-1:0] shadow_q;
  logic [MW-1:0]           m_q, m_d;
  logic                    m_valid_q;
  logic [CNT_W-1:0]        frame_cnt_q, err_cnt_q;
  logic                    s_ready, acc, emit, err_start;
  logic [IDX_W-1:0]        wr_idx;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: frame length is checked against the latched mode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (acc) begin
        idx_d   = IDX_W'(1);
        state_d = bus.s_last ? ERR : DATA;
      end
      DATA: if (acc) begin
        if (idx_q != LAST_IDX) begin
          if (bus.s_last) state_d = ERR;
          else            idx_d   = idx_q + IDX_W'(1);
        end else if (!mode_q) begin
          state_d = bus.s_last ? IDLE : DROP;
        end else begin
          state_d = bus.s_last ? ERR : CRCB;
        end
      end
      CRCB: if (acc) state_d = bus.s_last ? IDLE : DROP;
      DROP: if (acc && bus.s_last) state_d = ERR;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: handshake, emit/error strobes and the message to be written
  always_comb begin
    s_ready   = rst && (state_q != ERR);
    acc       = bus.s_valid && s_ready;
    emit      = acc && bus.s_last &&
                ((state_q == DATA && idx_q == LAST_IDX && !mode_q) || state_q == CRCB);
    err_start = acc && (state_d == ERR);
    wr_idx    = (state_q == IDLE) ? '0 : idx_q;
    // Final byte is folded in directly so emit needs no extra cycle
    m_d       = (state_q == CRCB) ? {shadow_q, bus.s_data}
                                  : {shadow_q[8*DATA_BYTES-1:8], bus.s_data, 8'h00};
  end

  // Datapath: shadow assembly, mode latch, message and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q      <= 1'b0;
      shadow_q    <= '0;
      m_q         <= '0;
      m_valid_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (acc && state_q == IDLE) mode_q <= bus.chk_mode;
      for (int i = 0; i < DATA_BYTES; i++)
        if (acc && (state_q == IDLE || state_q == DATA) && wr_idx == IDX_W'(i))
          shadow_q[8*(DATA_BYTES-1-i) +: 8] <= bus.s_data;
      m_valid_q <= emit;
      if (emit) m_q <= m_d;
      if (emit && frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      if (err_start && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign bus.s_ready   = s_ready;
  assign bus.M         = m_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.frm_err   = (state_q == ERR);
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: doc/crc8_msg_framer.md
# crc8_msg_framer

Upstream framing stage for the parallel CRC-8 pipeline. It collects a byte stream into one fixed-length message word and presents it on `M` in the `{data, crc_field}` layout the CRC-8 core consumes. In generate mode the framer appends a zero CRC byte; in check mode it takes the received CRC byte from the stream. Malformed frames are dropped and counted.

## Interface
- `DATA_BYTES`, 8: data bytes per frame; `M` width is `8*DATA_BYTES+8`; must be ≥2.
- `CNT_W`, 16: width of the frame and error counters.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `s_data`  in  8  stream byte.
- `s_valid`  in  1  byte valid.
- `s_last`  in  1  last byte of frame, qualified by `s_valid`.
- `s_ready`  out  1  framer accepts byte.
- `chk_mode`  in  1  0 = generate (append 8'h00), 1 = check (CRC byte from stream); sampled on frame's first byte.
- `M`  out  8*DATA_BYTES+8  framed message to the CRC core.
- `m_valid`  out  1  one-cycle pulse: `M` updated this cycle.
- `frm_err`  out  1  one-cycle pulse: malformed frame dropped.
- `frame_cnt`  out  CNT_W  good frames emitted, saturating.
- `err_cnt`  out  CNT_W  frames dropped, saturating.

## Operation
- A byte is accepted when `s_valid && s_ready`. The first byte of a frame goes to the MSB byte of `M` (`M[8*DATA_BYTES+7 -: 8]`). The last data byte goes to `M[15:8]`, and the CRC field goes to `M[7:0]`.
- Bytes are assembled in a shadow register. `M` is written only on a good frame, so partial data is never visible on `M`.
- The mode is latched on the first byte. `chk_mode` changes during a frame are ignored.
- States:
  - IDLE: on accept, latch mode and store byte 0, set idx=1. If `s_last`, go to ERR (short). Otherwise go to DATA.
  - DATA: on accept, store byte[idx].
    - If idx < DATA_BYTES-1: `s_last` goes to ERR (short); otherwise idx++.
    - If idx == DATA_BYTES-1, generate mode: `s_last` emits and goes to IDLE; no `s_last` goes to DROP (long).
    - If idx == DATA_BYTES-1, check mode: `s_last` goes to ERR (short); no `s_last` goes to CRCB.
  - CRCB: on accept, take the CRC byte. `s_last` emits and goes to IDLE; no `s_last` goes to DROP.
  - DROP: accept and discard bytes. `s_last` goes to ERR.
  - ERR: lasts one cycle. `frm_err`=1, `err_cnt`++, then go to IDLE.
- Emit: `M` <= {data bytes, mode ? crc_byte : 8'h00}; `m_valid` <= 1; `frame_cnt`++.
- `s_ready` = 1 in IDLE/DATA/CRCB/DROP, 0 in ERR, and 0 while `rst` is low.
- Counters saturate at all-ones and never wrap.
- Reset mid-frame discards the partial frame and clears all state.

## Timing
- Reset values: `M`=0, `m_valid`=0, `frm_err`=0, `frame_cnt`=0, `err_cnt`=0, state IDLE, `s_ready`=0 while in reset.
- `s_ready`=1 on the first clock after `rst` deasserts.
- Latency: `m_valid` and the new `M` appear one cycle after the final-byte handshake.
- `m_valid` is high for exactly one cycle. `M` holds its value until the next emit.
- Back-to-back frames: there is no bubble after a good frame. The next frame's first byte can be accepted in the cycle after the last byte.
- Error recovery: `frm_err` rises one cycle after the offending `s_last` handshake and lasts one cycle. `s_ready` is low for that same cycle.
- `s_valid` gaps: bytes may arrive with any number of idle cycles between them. State and index hold across gaps.
- `s_last` without `s_valid` is ignored.
- Counter saturation: at all-ones the counter holds, and `m_valid`/`frm_err` still pulse.

## Test plan
- Generate-mode frame, defaults: bytes 12 34 56 78 90 AB CD EF with `s_last` on EF, `chk_mode`=0 → one cycle later `M`=72'h1234567890ABCDEF00, `m_valid` pulses once, `frame_cnt`=1.
- Check-mode frame: same 8 bytes plus FA with `s_last` on FA, `chk_mode`=1 → `M`=72'h1234567890ABCDEFFA.
- Back-to-back frames: generate FEDCBA9876543210 immediately followed by check FEDCBA9876543210 + C9 → `M`=…1000, then …10C9. `m_valid` pulses 9 cycles apart, `s_ready` stays 1 throughout, `frame_cnt`=2.
- Short and long frames:
  - 3 bytes with `s_last` on the 3rd → `frm_err` pulse, one cycle of `s_ready`=0, `err_cnt`=1, no `m_valid`, `M` unchanged.
  - 10-byte generate frame → `frm_err` after the 10th byte, `err_cnt`=2, no `m_valid`.
- Reset and mode change mid-frame:
  - Assert `rst`=0 after 4 bytes → all outputs 0 immediately.
  - After release, a generate frame of 0F×8 → `M`=72'h0F0F0F0F0F0F0F0F00.
  - Toggle `chk_mode` to 1 on byte 3 of that frame → still treated as generate.
- Saturation: force `err_cnt` near the limit (CNT_W=2 build), inject 5 short frames → `err_cnt` sticks at 3, `frm_err` still pulses 5 times.
